// File: rtl/tx_pattern_pkg.sv
// Shared types, LFSR polynomial constants and index helpers for the parallel TX pattern source.
package tx_pattern_pkg;

  typedef enum logic [2:0] {
    ModePrbs7  = 3'd0,
    ModePrbs9  = 3'd1,
    ModePrbs15 = 3'd2,
    ModePrbs23 = 3'd3,
    ModePrbs31 = 3'd4,
    ModeFixed  = 3'd5,
    ModeClock  = 3'd6,
    ModeRsvd   = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StSeed,
    StRun
  } state_e;

  localparam int unsigned LfsrW = 31;

  // Polynomial x^Len + x^Tap + 1
  localparam int unsigned Prbs7Len  = 7;
  localparam int unsigned Prbs7Tap  = 6;
  localparam int unsigned Prbs9Len  = 9;
  localparam int unsigned Prbs9Tap  = 5;
  localparam int unsigned Prbs15Len = 15;
  localparam int unsigned Prbs15Tap = 14;
  localparam int unsigned Prbs23Len = 23;
  localparam int unsigned Prbs23Tap = 18;
  localparam int unsigned Prbs31Len = 31;
  localparam int unsigned Prbs31Tap = 28;

  function automatic logic [4:0] lfsr_len(mode_e m);
    case (m)
      ModePrbs7:  return 5'(Prbs7Len);
      ModePrbs9:  return 5'(Prbs9Len);
      ModePrbs15: return 5'(Prbs15Len);
      ModePrbs23: return 5'(Prbs23Len);
      default:    return 5'(Prbs31Len);
    endcase
  endfunction

  function automatic logic [4:0] lfsr_tap(mode_e m);
    case (m)
      ModePrbs7:  return 5'(Prbs7Tap);
      ModePrbs9:  return 5'(Prbs9Tap);
      ModePrbs15: return 5'(Prbs15Tap);
      ModePrbs23: return 5'(Prbs23Tap);
      default:    return 5'(Prbs31Tap);
    endcase
  endfunction

  function automatic logic [LfsrW-1:0] len_mask(logic [4:0] len);
    logic [LfsrW-1:0] m;
    for (int i = 0; i < int'(LfsrW); i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  // Output position of serial bit k; a factor of 1 presents the word MSB-first like fixed_pat.
  function automatic int unsigned interleave_idx(int unsigned k, int unsigned width,
                                                 int unsigned interleave);
    if (interleave <= 1) begin
      return width - 1 - k;
    end
    return (k % interleave) * (width / interleave) + k / interleave;
  endfunction

endpackage

// File: rtl/prbs_par_step.sv
// Combinational multi-step Fibonacci LFSR: WIDTH shifts per call, serial bits in transmit order.
module prbs_par_step
  import tx_pattern_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [LfsrW-1:0] state_i,
  input  logic [4:0]       len_i,
  input  logic [4:0]       tap_i,
  output logic [LfsrW-1:0] next_state_o,
  output logic [WIDTH-1:0] bits_o
);

  logic [LfsrW-1:0] mask;
  logic [LfsrW-1:0] st;
  logic             fb;

  always_comb begin
    mask   = len_mask(len_i);
    st     = state_i & mask;
    fb     = 1'b0;
    bits_o = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      fb        = st[len_i - 5'd1] ^ st[tap_i - 5'd1];
      bits_o[k] = fb;
      st        = {st[LfsrW-2:0], fb} & mask;
    end
    next_state_o = st;
  end

endmodule

// File: rtl/tx_pattern_gen_par.sv
// Parallel TX test-pattern source: shared LFSR, fixed/clock patterns, error injection, interleave.
module tx_pattern_gen_par
  import tx_pattern_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned INTERLEAVE = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             mode_load,
  input  logic [30:0]      seed,
  input  logic [WIDTH-1:0] fixed_pat,
  input  logic             inj_err,
  input  logic             invert,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             inj_done,
  output logic [CNT_W-1:0] inj_cnt
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [LfsrW-1:0] lfsr_q, lfsr_d, lfsr_step, seed_mask, seed_masked;
  logic [WIDTH-1:0] prbs_bits, ser, word, dout_d, dout_q;
  logic             inj_err_q, armed_q, armed_d, consume, in_run, prbs_mode;
  logic             valid_q, done_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_run    = (state_q == StRun);
  assign prbs_mode = (mode_q != ModeFixed) && (mode_q != ModeClock);

  prbs_par_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .state_i     (lfsr_q),
    .len_i       (lfsr_len(mode_q)),
    .tap_i       (lfsr_tap(mode_q)),
    .next_state_o(lfsr_step),
    .bits_o      (prbs_bits)
  );

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StSeed;
        StSeed:  state_d = StRun;
        StRun:   state_d = mode_load ? StSeed : StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  // Seed is masked to the length of the mode being loaded; all-zero would lock up.
  always_comb begin
    seed_mask   = len_mask(lfsr_len(mode_e'(mode)));
    seed_masked = seed & seed_mask;
    mode_d      = mode_q;
    lfsr_d      = lfsr_q;
    if (state_q == StSeed) begin
      mode_d = mode_e'(mode);
      lfsr_d = (seed_masked == '0) ? seed_mask : seed_masked;
    end else if (in_run && prbs_mode) begin
      lfsr_d = lfsr_step;
    end
  end

  always_comb begin
    consume = in_run && armed_q;
    armed_d = in_run && !armed_q && inj_err && !inj_err_q;
    cnt_d   = (consume && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_comb begin
    ser = prbs_bits;
    if (mode_q == ModeFixed) begin
      for (int unsigned k = 0; k < WIDTH; k++) ser[k] = fixed_pat[WIDTH-1-k];
    end else if (mode_q == ModeClock) begin
      for (int unsigned k = 0; k < WIDTH; k++) ser[k] = ((k % 2) == 0);
    end
    word   = ser ^ {{(WIDTH-1){1'b0}}, consume} ^ {WIDTH{invert}};
    dout_d = '0;
    if (in_run) begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        dout_d[interleave_idx(k, WIDTH, INTERLEAVE)] = word[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mode_q    <= ModePrbs7;
      lfsr_q    <= '1;
      inj_err_q <= 1'b0;
      armed_q   <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      lfsr_q    <= lfsr_d;
      inj_err_q <= inj_err;
      armed_q   <= armed_d;
      dout_q    <= dout_d;
      valid_q   <= in_run;
      done_q    <= consume;
      cnt_q     <= cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign inj_done   = done_q;
  assign inj_cnt    = cnt_q;

endmodule

// File: tb/tb_tx_pattern_gen_par.sv
// Bench for tx_pattern_gen_par: recurrence-based golden stream scoreboard plus fixed-pattern table.
module tb_tx_pattern_gen_par;

  logic        clk = 1'b0;
  logic        rst_n, en, mode_load, inj_err, invert;
  logic [2:0]  mode;
  logic [30:0] seed;
  logic [15:0] fixed_pat;
  logic [15:0] dout1, dout4, c1, c4;
  logic        v1, v4, d1, d4;

  always #5 clk = ~clk;

  tx_pattern_gen_par #(.WIDTH(16), .INTERLEAVE(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .mode_load(mode_load), .seed(seed),
    .fixed_pat(fixed_pat), .inj_err(inj_err), .invert(invert), .dout(dout1),
    .dout_valid(v1), .inj_done(d1), .inj_cnt(c1)
  );

  tx_pattern_gen_par #(.WIDTH(16), .INTERLEAVE(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .mode_load(mode_load), .seed(seed),
    .fixed_pat(fixed_pat), .inj_err(inj_err), .invert(invert), .dout(dout4),
    .dout_valid(v4), .inj_done(d4), .inj_cnt(c4)
  );

  typedef struct {
    logic [15:0] w1;
    logic [15:0] w4;
    logic        done;
  } exp_t;

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] pat;
    logic        inv;
    logic [15:0] exp1;
    logic [15:0] exp4;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  bit   hist[$];
  int   g_n, g_t;
  int   n_of[5] = '{7, 9, 15, 23, 31};
  int   t_of[5] = '{6, 5, 14, 18, 28};
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] map1(logic [15:0] s);
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[15-k] = s[k];
    return r;
  endfunction

  function automatic logic [15:0] map4(logic [15:0] s);
    logic [15:0] r;
    for (int j = 0; j < 4; j++)
      for (int m = 0; m < 4; m++) r[j*4+m] = s[m*4+j];
    return r;
  endfunction

  // History window holds s[k-N]..s[k-1]; seed bit i is s[-1-i].
  task automatic golden_init(input int n, input int t, input logic [30:0] sd);
    logic [31:0] m32;
    logic [30:0] eff;
    m32 = (32'h1 << n) - 32'h1;
    eff = sd & m32[30:0];
    if (eff == '0) eff = m32[30:0];
    g_n = n;
    g_t = t;
    hist.delete();
    for (int i = n - 1; i >= 0; i--) hist.push_back(eff[i]);
  endtask

  task automatic golden_word(output logic [15:0] s);
    bit b;
    for (int k = 0; k < 16; k++) begin
      b    = hist[0] ^ hist[g_n-g_t];
      s[k] = b;
      hist.push_back(b);
      void'(hist.pop_front());
    end
  endtask

  // Counts dout_valid-low samples between the kick edge and the first valid word.
  task automatic wait_valid(input int exp_zeros, output bit ok);
    int zeros = 0;
    int g     = 0;
    bit seen0 = 1'b0;
    while (g < 16 && !(seen0 && v1)) begin
      if (!v1) begin
        seen0 = 1'b1;
        zeros++;
      end
      tick();
      g++;
    end
    ok = seen0 && v1;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL valid_timeout: dout_valid not seen after %0d cycles, required within 16", g);
    end else begin
      check("valid_gap", zeros, exp_zeros);
    end
  endtask

  task automatic run_prbs(input logic [2:0] m, input logic [30:0] sd, input logic [30:0] gsd,
                          input int gm, input int nw, input bit use_load, input int inj_at);
    exp_t        e, t;
    logic [15:0] s;
    bit          ok;
    int          hold = 0;
    golden_init(n_of[gm], t_of[gm], gsd);
    for (int i = 0; i < nw; i++) begin
      golden_word(s);
      e.w1   = map1(s);
      e.w4   = map4(s);
      e.done = 1'b0;
      sb.push_back(e);
    end
    mode = m;
    seed = sd;
    if (use_load) mode_load = 1'b1;
    else en = 1'b1;
    tick();
    mode_load = 1'b0;
    wait_valid(use_load ? 1 : 2, ok);
    if (!ok) begin
      sb.delete();
      return;
    end
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      check("valid", v1, 1'b1);
      check("word_il1", dout1, e.w1);
      check("word_il4", dout4, e.w4);
      check("inj_done_il1", d1, e.done);
      check("inj_done_il4", d4, e.done);
      if (i == inj_at && sb.size() > 1) begin
        inj_err = 1'b1;
        hold    = 5;
        t       = sb[1];
        t.w1    = t.w1 ^ 16'h8000;
        t.w4    = t.w4 ^ 16'h0001;
        t.done  = 1'b1;
        sb[1]   = t;
      end
      tick();
      if (hold > 0) begin
        hold--;
        if (hold == 0) inj_err = 1'b0;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [30:0] s;
    bit          ok;
    vecs[0] = '{3'd5, 16'hA5C3, 1'b0, 16'hA5C3, 16'hA965};
    vecs[1] = '{3'd5, 16'hA5C3, 1'b1, 16'h5A3C, 16'h569A};
    vecs[2] = '{3'd6, 16'h0000, 1'b0, 16'hAAAA, 16'h0F0F};
    vecs[3] = '{3'd6, 16'h1234, 1'b1, 16'h5555, 16'hF0F0};
    vecs[4] = '{3'd5, 16'h8000, 1'b0, 16'h8000, 16'h0001};
    vecs[5] = '{3'd5, 16'h0001, 1'b0, 16'h0001, 16'h8000};
    vecs[6] = '{3'd5, 16'hFFFF, 1'b1, 16'h0000, 16'h0000};

    rst_n = 1'b0; en = 1'b0; mode = 3'd0; mode_load = 1'b0; seed = '0;
    fixed_pat = '0; inj_err = 1'b0; invert = 1'b0;
    repeat (3) tick();
    check("rst_dout_il1", dout1, 16'h0);
    check("rst_dout_il4", dout4, 16'h0);
    check("rst_valid", v1, 1'b0);
    check("rst_inj_done", d1, 1'b0);
    check("rst_inj_cnt", c1, 16'h0);
    rst_n = 1'b1;
    tick();

    run_prbs(3'd0, 31'h7F, 31'h7F, 0, 4096, 1'b0, -1);
    for (int m = 1; m <= 4; m++) begin
      s = 31'($urandom);
      run_prbs(3'(m), s, s, m, 4096, 1'b1, -1);
    end
    run_prbs(3'd2, 31'h0, 31'h7FFF, 2, 64, 1'b1, -1);

    for (int v = 0; v < 7; v++) begin
      mode      = vecs[v].mode;
      fixed_pat = vecs[v].pat;
      invert    = vecs[v].inv;
      mode_load = 1'b1;
      tick();
      mode_load = 1'b0;
      wait_valid(1, ok);
      if (ok) begin
        for (int r = 0; r < 2; r++) begin
          check("table_il1", dout1, vecs[v].exp1);
          check("table_il4", dout4, vecs[v].exp4);
          tick();
        end
      end
    end
    invert = 1'b0;

    check("inj_cnt_pre_il1", c1, 16'h0);
    check("inj_cnt_pre_il4", c4, 16'h0);
    s = 31'($urandom);
    run_prbs(3'd4, s, s, 4, 200, 1'b1, 50);
    check("inj_cnt_post_il1", c1, 16'h1);
    check("inj_cnt_post_il4", c4, 16'h1);
    s = 31'($urandom);
    run_prbs(3'd7, s, s, 4, 128, 1'b1, -1);

    rst_n = 1'b0;
    en    = 1'b0;
    tick();
    check("midrst_dout", dout1, 16'h0);
    check("midrst_valid", v1, 1'b0);
    check("midrst_inj_done", d1, 1'b0);
    check("midrst_inj_cnt", c1, 16'h0);
    rst_n = 1'b1;
    tick();
    run_prbs(3'd1, 31'h1AB, 31'h1AB, 1, 64, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
